// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - multi-rate tick source: base divider plus cascaded tap stages
// Runtime divisor reloads go through a shadow register and take effect only at base wraps or on clear.
module tick_generator #(
  parameter int BASE_DIV  = 100000,
  parameter int CNT_W     = 17,
  parameter int NUM_TAPS  = 4,
  parameter int TAP_RATIO = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic                div_load,
  input  logic [CNT_W-1:0]    div_value,
  output logic [NUM_TAPS-1:0] tick,
  output logic [CNT_W-1:0]    div_active,
  output logic                load_pending
);

  localparam int TAP_W = $clog2(TAP_RATIO);
  localparam logic [TAP_W-1:0] TAP_LAST  = TAP_W'(TAP_RATIO - 1);
  localparam logic [CNT_W-1:0] DIV_RESET = CNT_W'(BASE_DIV - 1);

  logic [CNT_W-1:0]    base_cnt_q, base_cnt_d;
  logic [TAP_W-1:0]    tap_cnt_q [NUM_TAPS];
  logic [TAP_W-1:0]    tap_cnt_d [NUM_TAPS];
  logic [NUM_TAPS-1:0] tick_q, tick_d;
  logic [CNT_W-1:0]    div_active_q, div_active_d;
  logic [CNT_W-1:0]    shadow_q, shadow_d;
  logic                load_pending_q, load_pending_d;
  logic [NUM_TAPS-1:0] wrap;
  logic                pending_any;
  logic                apply_div;

  always_comb begin
    wrap       = '0;
    base_cnt_d = base_cnt_q;
    tap_cnt_d  = tap_cnt_q;
    tap_cnt_d[0] = '0;

    if (clear) begin
      base_cnt_d = '0;
      for (int i = 1; i < NUM_TAPS; i++) tap_cnt_d[i] = '0;
    end else if (enable) begin
      wrap[0]    = (base_cnt_q == div_active_q);
      base_cnt_d = wrap[0] ? '0 : base_cnt_q + 1'b1;
      // Each tap only moves on its predecessor's wrap, so all taps fire coincidentally.
      for (int i = 1; i < NUM_TAPS; i++) begin
        if (wrap[i-1]) begin
          if (tap_cnt_q[i] == TAP_LAST) begin
            tap_cnt_d[i] = '0;
            wrap[i]      = 1'b1;
          end else begin
            tap_cnt_d[i] = tap_cnt_q[i] + 1'b1;
          end
        end
      end
    end

    tick_d = wrap;

    // A load in the same cycle as a wrap or clear is applied right away.
    shadow_d       = div_load ? div_value : shadow_q;
    pending_any    = div_load | load_pending_q;
    apply_div      = pending_any & (clear | wrap[0]);
    div_active_d   = apply_div ? shadow_d : div_active_q;
    load_pending_d = pending_any & ~apply_div;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_cnt_q     <= '0;
      for (int i = 0; i < NUM_TAPS; i++) tap_cnt_q[i] <= '0;
      tick_q         <= '0;
      div_active_q   <= DIV_RESET;
      shadow_q       <= DIV_RESET;
      load_pending_q <= 1'b0;
    end else begin
      base_cnt_q     <= base_cnt_d;
      for (int i = 0; i < NUM_TAPS; i++) tap_cnt_q[i] <= tap_cnt_d[i];
      tick_q         <= tick_d;
      div_active_q   <= div_active_d;
      shadow_q       <= shadow_d;
      load_pending_q <= load_pending_d;
    end
  end

  assign tick         = tick_q;
  assign div_active   = div_active_q;
  assign load_pending = load_pending_q;

endmodule
